serial_adder: RTL

- Bit-serial two's-complement adder, LSB first, one bit per clock.
- Gives the 8BitAlu a low-area add path for the area-constrained configuration.
- Result format matches the combinational subtract path: a SIZE+1-bit sign-extended exact result plus a SIZE-bit signed overflow flag.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/serial_adder_if.sv | 23 ++
 rtl/serial_fa_cell.sv | 11 +
 rtl/serial_adder.sv | 91 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial adder state encoding and a width helper.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_t;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result handshakes for the bit-serial adder.
interface serial_adder_if #(
  parameter int SIZE = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE:0]   result;
  logic            overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder used by the serial datapath.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder, LSB first, SIZE+1 bit-cycles per sum.
//   state | meaning
//   IDLE  | ready for operands
//   RUN   | adding one bit per clock
//   DONE  | result presented until out_ready
module serial_adder
  import alu_pkg::*;
#(
  parameter int SIZE = 8
) (
  input logic         clk,
  input logic         rst_n,
  serial_adder_if.slave bus
);

  localparam int                CNT_W    = clog2(SIZE + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SIZE);

  serial_state_t    state_q;
  logic [SIZE:0]    op_a_q;
  logic [SIZE:0]    op_b_q;
  logic [SIZE:0]    res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             ovf_q;

  logic             sum_bit;
  logic             carry_next;
  logic [SIZE:0]    res_next;

  serial_fa_cell u_fa (
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cin  (carry_q),
    .s    (sum_bit),
    .cout (carry_next)
  );

  assign res_next = {sum_bit, res_q[SIZE:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_a_q  <= {bus.a[SIZE-1], bus.a};
            op_b_q  <= {bus.b[SIZE-1], bus.b};
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_next;
          op_a_q  <= op_a_q >> 1;
          op_b_q  <= op_b_q >> 1;
          carry_q <= carry_next;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // Final carry out is dropped; the SIZE+1-bit sum is already exact.
            ovf_q   <= res_next[SIZE] ^ res_next[SIZE-1];
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ovf_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.overflow  = ovf_q;

endmodule
